spu_simd_alu: RTL and testbench
===============================

SPU_SIMD_ALU -- requirements
Module: spu_simd_alu

Interface
REQ-001 SHALL have parameter DATA_W, default 128, vector width in bits.
REQ-002 SHALL have parameter LANE_W, default 32, lane width in bits; legal values 8/16/32/64, and DATA_W SHALL be a multiple of LANE_W.
REQ-003 SHALL have parameter LATENCY, default 2, pipeline depth in cycles; legal range 1..4.
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 in_valid  input  1  operands and opcode present.
REQ-008 in_ready  output  1  stage 0 can accept.
REQ-009 a, b  input  DATA_W  operand vectors.
REQ-010 ALUctr  input  4  opcode.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  consumer accepts.
REQ-013 out  output  DATA_W  result vector.
REQ-014 zero_signal  output  1  out is all zeros.
REQ-015 illegal_op  output  1  the result's opcode was unsupported.

Function
REQ-016 SHALL accept a transfer when in_valid && in_ready, and SHALL deliver it when out_valid && out_ready.
REQ-017 SHALL present the result exactly LATENCY cycles after acceptance when out_ready is held high.
REQ-018 SHALL sustain one transfer per cycle with no bubbles while out_ready=1.
REQ-019 SHALL freeze all stages when out_valid && !out_ready, and SHALL drive in_ready=0 only in that case; out, zero_signal and illegal_op SHALL stay stable while stalled.
REQ-020 SHALL operate per lane with no carry or shift crossing lane boundaries: 0000 a-b, 0001 a+b, 0010 AND, 0011 OR, 0100 XOR, 0101 a<<b, 0110 a>>b (logical), 0111 a*b, 1000 compare-equal, 1111 pass a.
REQ-021 Add, subtract and multiply SHALL wrap modulo 2^LANE_W; multiply SHALL return the low LANE_W bits of the product.
REQ-022 Shift amount SHALL be the lane's b[$clog2(LANE_W):0]; an amount >= LANE_W SHALL give lane result 0.
REQ-023 Compare-equal SHALL set the lane to all ones if a==b, else to 0.
REQ-024 Any other opcode SHALL produce out=0 with illegal_op=1; a legal opcode SHALL produce illegal_op=0.
REQ-025 zero_signal SHALL equal (out==0) for the presented result, and SHALL be qualified by out_valid.
REQ-026 Input changes while !in_ready SHALL have no effect.

Reset
REQ-027 Asserting rst at any time, including mid-pipeline, SHALL immediately clear all stage valids, discarding in-flight results.
REQ-028 During reset: out_valid=0, out=0, zero_signal=1, illegal_op=0, in_ready=1.
REQ-029 The first acceptance SHALL be possible on the first rising edge after rst deasserts.

Configuration
REQ-030 With SPU_ALU_SAT_EN defined, opcode 1001 SHALL perform a per-lane signed saturating add clamped to [-2^(LANE_W-1), 2^(LANE_W-1)-1], and opcode 1010 SHALL perform the signed saturating subtract.
REQ-031 Without SPU_ALU_SAT_EN, opcodes 1001 and 1010 SHALL be treated as illegal per REQ-024.

Structure
REQ-032 Package spu_alu_pkg SHALL hold the opcode enum (4-bit) and the legal LANE_W constants.
REQ-033 Sub-module spu_alu_lane (combinational, one lane, parameter LANE_W) SHALL be instantiated DATA_W/LANE_W times.
REQ-034 The pipeline registers and valid chain SHALL live in spu_simd_alu.

Verification
REQ-035 LANE_W=32, a=lanes{10,10,10,10}, b=lanes{5,5,5,5}, 0000 -> out=lanes{5,5,5,5}, zero_signal=0, out_valid exactly LATENCY cycles after acceptance.
REQ-036 LANE_W=8, a=all 0xFF, b=all 0x01, 0001 -> out=0, zero_signal=1 (no inter-lane carry); 0101 with b lane = 8 -> lane 0.
REQ-037 Back-to-back ops 0000 through 1000 with out_ready=1, then out_ready=0 for 3 cycles -> in_ready=0, out held constant, no result lost or duplicated, order preserved.
REQ-038 a lane 0 = 10, b lane 0 = 10, other lanes unequal, 1000 -> lane 0 all ones, other lanes 0; opcode 1100 -> out=0, illegal_op=1.
REQ-039 rst pulsed with LATENCY results in flight -> out_valid=0 immediately, and no stale result appears after release.
REQ-040 SPU_ALU_SAT_EN, LANE_W=16, a lane=0x7FFF, b lane=1, 1001 -> 0x7FFF; without the macro -> illegal_op=1.

Source files
------------

// File: rtl/spu_alu_pkg.sv
// spu_alu_pkg -- shared definitions for the SIMD ALU.
//   alu_op_e      : 4-bit opcode encoding (ALUctr)
//   LANE_W_*      : the supported lane widths
//   op_is_legal() : opcode legality for the current build
// Optional feature macro: SPU_ALU_SAT_EN (adds signed saturating add/sub).
package spu_alu_pkg;

  typedef enum logic [3:0] {
    OP_SUB   = 4'b0000,
    OP_ADD   = 4'b0001,
    OP_AND   = 4'b0010,
    OP_OR    = 4'b0011,
    OP_XOR   = 4'b0100,
    OP_SHL   = 4'b0101,
    OP_SHR   = 4'b0110,
    OP_MUL   = 4'b0111,
    OP_CMPEQ = 4'b1000,
    OP_SADD  = 4'b1001,
    OP_SSUB  = 4'b1010,
    OP_PASS  = 4'b1111
  } alu_op_e;

  localparam int unsigned LANE_W_8  = 8;
  localparam int unsigned LANE_W_16 = 16;
  localparam int unsigned LANE_W_32 = 32;
  localparam int unsigned LANE_W_64 = 64;

  // The saturating opcodes only count as legal when the feature is built in.
  function automatic logic op_is_legal(input logic [3:0] op);
    logic legal;
    case (op)
      OP_SUB, OP_ADD, OP_AND, OP_OR, OP_XOR,
      OP_SHL, OP_SHR, OP_MUL, OP_CMPEQ, OP_PASS: legal = 1'b1;
`ifdef SPU_ALU_SAT_EN
      OP_SADD, OP_SSUB:                          legal = 1'b1;
`endif
      default:                                   legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/spu_simd_alu_if.sv
// spu_simd_alu_if -- operand/result bus of the SIMD ALU.
//   in_valid/in_ready, a, b, ALUctr          : request side
//   out_valid/out_ready, out, zero_signal,
//   illegal_op                               : result side
// Handshake: a beat moves on a rising edge where valid && ready. A producer
// holding valid keeps its payload stable until the beat moves; ready may be
// observed before valid and never depends on the same-side valid.
interface spu_simd_alu_if #(
  parameter int DATA_W = 128
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [3:0]        ALUctr;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out;
  logic              zero_signal;
  logic              illegal_op;

  modport master (
    output in_valid, a, b, ALUctr, out_ready,
    input  in_ready, out_valid, out, zero_signal, illegal_op
  );

  modport slave (
    input  in_valid, a, b, ALUctr, out_ready,
    output in_ready, out_valid, out, zero_signal, illegal_op
  );
endinterface

// File: rtl/spu_alu_lane.sv
// spu_alu_lane -- combinational datapath for one SIMD lane.
//   a_i, b_i : lane operands (LANE_W bits)
//   op_i     : opcode (alu_op_e encoding)
//   res_o    : lane result; 0 for an unsupported opcode
// Optional feature macro: SPU_ALU_SAT_EN (opcodes 1001/1010).
module spu_alu_lane
  import spu_alu_pkg::*;
#(
  parameter int LANE_W = 32
) (
  input  logic [LANE_W-1:0] a_i,
  input  logic [LANE_W-1:0] b_i,
  input  logic [3:0]        op_i,
  output logic [LANE_W-1:0] res_o
);

  // One extra bit of shift amount so that amounts >= LANE_W are visible.
  localparam int              SH_W     = $clog2(LANE_W) + 1;
  localparam logic [SH_W-1:0] SH_LIMIT = SH_W'(LANE_W);

  logic [SH_W-1:0]   sh_amt;
  logic [LANE_W-1:0] sum;
  logic [LANE_W-1:0] diff;
  logic [LANE_W-1:0] prod;

  assign sh_amt = b_i[SH_W-1:0];
  assign sum    = a_i + b_i;
  assign diff   = a_i - b_i;
  assign prod   = a_i * b_i;  // truncated to the low LANE_W bits

`ifdef SPU_ALU_SAT_EN
  localparam logic [LANE_W-1:0] S_MAX = {1'b0, {(LANE_W-1){1'b1}}};
  localparam logic [LANE_W-1:0] S_MIN = {1'b1, {(LANE_W-1){1'b0}}};

  logic              add_ovf;
  logic              sub_ovf;
  logic [LANE_W-1:0] clamp;

  // Signed overflow can only go towards the sign of a, so a's sign picks the rail.
  assign add_ovf = (a_i[LANE_W-1] == b_i[LANE_W-1]) && (sum[LANE_W-1]  != a_i[LANE_W-1]);
  assign sub_ovf = (a_i[LANE_W-1] != b_i[LANE_W-1]) && (diff[LANE_W-1] != a_i[LANE_W-1]);
  assign clamp   = a_i[LANE_W-1] ? S_MIN : S_MAX;
`endif

  always_comb begin
    res_o = '0;
    case (op_i)
      OP_SUB:   res_o = diff;
      OP_ADD:   res_o = sum;
      OP_AND:   res_o = a_i & b_i;
      OP_OR:    res_o = a_i | b_i;
      OP_XOR:   res_o = a_i ^ b_i;
      OP_SHL:   res_o = (sh_amt >= SH_LIMIT) ? '0 : (a_i << sh_amt);
      OP_SHR:   res_o = (sh_amt >= SH_LIMIT) ? '0 : (a_i >> sh_amt);
      OP_MUL:   res_o = prod;
      OP_CMPEQ: res_o = (a_i == b_i) ? '1 : '0;
`ifdef SPU_ALU_SAT_EN
      OP_SADD:  res_o = add_ovf ? clamp : sum;
      OP_SSUB:  res_o = sub_ovf ? clamp : diff;
`endif
      OP_PASS:  res_o = a_i;
      default:  res_o = '0;
    endcase
  end

endmodule

// File: rtl/spu_simd_alu.sv
// spu_simd_alu -- pipelined SIMD ALU, DATA_W/LANE_W independent lanes.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset, clears every stage valid
//   bus  : spu_simd_alu_if.slave (operands/opcode in, result/flags out)
// Parameters: DATA_W (multiple of LANE_W), LANE_W (8/16/32/64), LATENCY (1..4).
// Result appears LATENCY cycles after acceptance; the whole pipe freezes
// while a result is presented and not taken.
// Optional feature macro: SPU_ALU_SAT_EN (signed saturating add/sub).
module spu_simd_alu
  import spu_alu_pkg::*;
#(
  parameter int DATA_W  = 128,
  parameter int LANE_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic           clk,
  input  logic           rst,
  spu_simd_alu_if.slave  bus
);

  localparam int N_LANES = DATA_W / LANE_W;

  // Stage-0 next-state values, computed straight from the bus.
  logic [DATA_W-1:0] res_d;
  logic              zero_d;
  logic              ill_d;

  for (genvar g = 0; g < N_LANES; g++) begin : g_lane
    spu_alu_lane #(
      .LANE_W(LANE_W)
    ) u_lane (
      .a_i  (bus.a[g*LANE_W +: LANE_W]),
      .b_i  (bus.b[g*LANE_W +: LANE_W]),
      .op_i (bus.ALUctr),
      .res_o(res_d[g*LANE_W +: LANE_W])
    );
  end

  assign ill_d  = !op_is_legal(bus.ALUctr);
  assign zero_d = (res_d == '0);

  logic [LATENCY-1:0] vld_q;
  logic [LATENCY-1:0] zero_q;
  logic [LATENCY-1:0] ill_q;
  logic [DATA_W-1:0]  data_q [LATENCY];
  logic               advance;

  // Only a presented-but-refused result stops the pipe; bubbles never do.
  assign advance = !(vld_q[LATENCY-1] && !bus.out_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= '0;
      zero_q <= '1;
      ill_q  <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        data_q[i] <= '0;
      end
    end else if (advance) begin
      vld_q[0]  <= bus.in_valid;
      zero_q[0] <= zero_d;
      ill_q[0]  <= ill_d;
      data_q[0] <= res_d;
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i]  <= vld_q[i-1];
        zero_q[i] <= zero_q[i-1];
        ill_q[i]  <= ill_q[i-1];
        data_q[i] <= data_q[i-1];
      end
    end
  end

  // With no valid result the visible vector is 0, so zero_signal reads 1.
  assign bus.in_ready    = advance;
  assign bus.out_valid   = vld_q[LATENCY-1];
  assign bus.out         = vld_q[LATENCY-1] ? data_q[LATENCY-1] : '0;
  assign bus.zero_signal = !vld_q[LATENCY-1] || zero_q[LATENCY-1];
  assign bus.illegal_op  = vld_q[LATENCY-1] && ill_q[LATENCY-1];

endmodule

// File: tb/tb_spu_simd_alu.sv
// tb_spu_simd_alu -- directed bench for spu_simd_alu.
// Three instances share clk/rst: 4x32-bit lanes (LATENCY 2), 4x8-bit lanes
// (LATENCY 3) and 4x16-bit lanes (LATENCY 1).
module tb_spu_simd_alu;
  import spu_alu_pkg::*;

  localparam int L32 = 2;
  localparam int L8  = 3;
  localparam int L16 = 1;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  logic [127:0] exp_q[$];

  always #5 clk = ~clk;

  spu_simd_alu_if #(.DATA_W(128)) if32 ();
  spu_simd_alu_if #(.DATA_W(32))  if8 ();
  spu_simd_alu_if #(.DATA_W(64))  if16 ();

  spu_simd_alu #(.DATA_W(128), .LANE_W(32), .LATENCY(L32)) u_dut32 (.clk(clk), .rst(rst), .bus(if32));
  spu_simd_alu #(.DATA_W(32),  .LANE_W(8),  .LATENCY(L8))  u_dut8  (.clk(clk), .rst(rst), .bus(if8));
  spu_simd_alu #(.DATA_W(64),  .LANE_W(16), .LATENCY(L16)) u_dut16 (.clk(clk), .rst(rst), .bus(if16));

  // ---------------- driver tasks ----------------
  task automatic set_in(input int dut, input logic v, input logic [127:0] a,
                        input logic [127:0] b, input logic [3:0] op);
    case (dut)
      0: begin if32.in_valid = v; if32.a = a;         if32.b = b;         if32.ALUctr = op; end
      1: begin if8.in_valid  = v; if8.a  = a[31:0];  if8.b  = b[31:0];  if8.ALUctr  = op; end
      default: begin if16.in_valid = v; if16.a = a[63:0]; if16.b = b[63:0]; if16.ALUctr = op; end
    endcase
  endtask

  task automatic get_out(input int dut, output logic vld, output logic [127:0] res,
                         output logic zero, output logic ill, output logic rdy);
    case (dut)
      0: begin vld = if32.out_valid; res = if32.out; zero = if32.zero_signal;
               ill = if32.illegal_op; rdy = if32.in_ready; end
      1: begin vld = if8.out_valid; res = {96'b0, if8.out}; zero = if8.zero_signal;
               ill = if8.illegal_op; rdy = if8.in_ready; end
      default: begin vld = if16.out_valid; res = {64'b0, if16.out}; zero = if16.zero_signal;
               ill = if16.illegal_op; rdy = if16.in_ready; end
    endcase
  endtask

  // One operation with out_ready=1. lat counts rising edges from the accepting
  // edge (inclusive) to the first one after which out_valid is seen; -1 on timeout.
  task automatic issue(input int dut, input logic [127:0] a, input logic [127:0] b,
                       input logic [3:0] op, output logic [127:0] res, output logic zero,
                       output logic ill, output int lat, output logic rdy);
    logic vld, r2, found;
    int   k;
    set_in(dut, 1'b1, a, b, op);
    #1;
    get_out(dut, vld, res, zero, ill, rdy);
    @(posedge clk); #1;
    set_in(dut, 1'b0, '0, '0, 4'h0);
    lat = -1;
    found = 1'b0;
    k = 1;
    while (!found && k <= 20) begin
      get_out(dut, vld, res, zero, ill, r2);
      if (vld) begin
        found = 1'b1;
        lat = k;
      end else begin
        @(posedge clk); #1;
        k++;
      end
    end
  endtask

  task automatic idle_cycle();
    for (int d = 0; d < 3; d++) set_in(d, 1'b0, '0, '0, 4'h0);
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic vld, zero, ill, rdy;
    logic [127:0] res;
    rst = 1'b1;
    for (int d = 0; d < 3; d++) set_in(d, 1'b0, '0, '0, 4'h0);
    if32.out_ready = 1'b1; if8.out_ready = 1'b1; if16.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      get_out(d, vld, res, zero, ill, rdy);
      checks++;
      if (vld !== 1'b0 || res !== 128'd0 || zero !== 1'b1 || ill !== 1'b0 || rdy !== 1'b1) begin
        failures++;
        $display("FAIL reset_state dut=%0d got vld=%b out=%h zero=%b ill=%b rdy=%b want 0/0/1/0/1",
                 d, vld, res, zero, ill, rdy);
      end
    end
    rst = 1'b0;
  endtask

  // Starts right after reset release: the first edge must accept.
  task automatic test_latency();
    logic [127:0] res;
    logic zero, ill, rdy;
    int lat;
    issue(0, {4{32'd10}}, {4{32'd5}}, OP_SUB, res, zero, ill, lat, rdy);
    checks++;
    if (rdy !== 1'b1) begin failures++; $display("FAIL first_accept_ready got %b want 1", rdy); end
    checks++;
    if (lat != L32) begin failures++; $display("FAIL sub_latency got %0d want %0d", lat, L32); end
    checks++;
    if (res !== {4{32'd5}} || zero !== 1'b0 || ill !== 1'b0) begin
      failures++;
      $display("FAIL sub_result got out=%h zero=%b ill=%b want %h 0 0", res, zero, ill, {4{32'd5}});
    end
  endtask

  task automatic test_lane8();
    logic [31:0] av[7], bv[7], ev[7];
    logic [3:0]  ov[7];
    logic [127:0] res;
    logic zero, ill, rdy;
    int lat;
    av = '{32'hFFFFFFFF, 32'h81818181, 32'h81818181, 32'h81818181, 32'h0F0F0F0F, 32'h00000000, 32'h81818181};
    bv = '{32'h01010101, 32'h08080808, 32'h03030303, 32'h07070707, 32'h11111111, 32'h01010101, 32'h10101010};
    ov = '{OP_ADD,       OP_SHL,       OP_SHL,       OP_SHR,       OP_MUL,       OP_SUB,       OP_SHL};
    ev = '{32'h00000000, 32'h00000000, 32'h08080808, 32'h01010101, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h81818181};
    idle_cycle();
    for (int i = 0; i < 7; i++) begin
      issue(1, {96'b0, av[i]}, {96'b0, bv[i]}, ov[i], res, zero, ill, lat, rdy);
      checks++;
      if (res[31:0] !== ev[i] || lat != L8) begin
        failures++;
        $display("FAIL lane8_vec%0d got out=%h lat=%0d want %h lat=%0d", i, res[31:0], lat, ev[i], L8);
      end
      checks++;
      if (zero !== (ev[i] == 32'd0) || ill !== 1'b0) begin
        failures++;
        $display("FAIL lane8_flags%0d got zero=%b ill=%b want zero=%b ill=0", i, zero, ill, ev[i] == 32'd0);
      end
    end
  endtask

  task automatic test_cmp_illegal();
    logic [127:0] av, bv, ev[5];
    logic [3:0]   ov[5];
    logic         iv[5];
    logic [127:0] res;
    logic zero, ill, rdy;
    int lat;
    av = {32'd1, 32'd2, 32'd3, 32'd10};
    bv = {32'd4, 32'd5, 32'd6, 32'd10};
    ov = '{OP_CMPEQ, 4'b1100, 4'b1110, OP_PASS, 4'b1011};
    ev = '{{96'd0, 32'hFFFFFFFF}, 128'd0, 128'd0, {32'd1, 32'd2, 32'd3, 32'd10}, 128'd0};
    iv = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    idle_cycle();
    for (int i = 0; i < 5; i++) begin
      issue(0, av, bv, ov[i], res, zero, ill, lat, rdy);
      checks++;
      if (res !== ev[i] || ill !== iv[i] || zero !== (ev[i] == 128'd0) || lat != L32) begin
        failures++;
        $display("FAIL cmp_illegal op=%b got out=%h ill=%b zero=%b lat=%0d want %h ill=%b zero=%b lat=%0d",
                 ov[i], res, ill, zero, lat, ev[i], iv[i], ev[i] == 128'd0, L32);
      end
    end
  endtask

  task automatic test_sat();
    logic [15:0] av[5], bv[5], ev[5];
    logic [3:0]  ov[5];
    logic        iv[5];
    logic [127:0] res;
    logic zero, ill, rdy;
    int lat;
    av = '{16'h7FFF, 16'h8000, 16'h0001, 16'h8000, 16'h7FFF};
    bv = '{16'h0001, 16'h0001, 16'h0002, 16'hFFFF, 16'h0001};
    ov = '{OP_SADD,  OP_SSUB,  OP_SADD,  OP_SADD,  OP_ADD};
`ifdef SPU_ALU_SAT_EN
    ev = '{16'h7FFF, 16'h8000, 16'h0003, 16'h8000, 16'h8000};
    iv = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`else
    ev = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h8000};
    iv = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`endif
    idle_cycle();
    for (int i = 0; i < 5; i++) begin
      issue(2, {64'b0, {4{av[i]}}}, {64'b0, {4{bv[i]}}}, ov[i], res, zero, ill, lat, rdy);
      checks++;
      if (res[63:0] !== {4{ev[i]}} || ill !== iv[i] || lat != L16) begin
        failures++;
        $display("FAIL sat_vec%0d got out=%h ill=%b lat=%0d want %h ill=%b lat=%0d",
                 i, res[63:0], ill, lat, {4{ev[i]}}, iv[i], L16);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]   ops[9];
    logic [31:0]  expv[9];
    logic [127:0] a_v, b_v, held, exp_v;
    logic         have_held;
    int idx, delivered, stall_seen;
    ops  = '{OP_SUB, OP_ADD, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_MUL, OP_CMPEQ};
    expv = '{32'h800000EF, 32'h800000F7, 32'h00000000, 32'h800000F7, 32'h800000F7,
             32'h00000F30, 32'h0800000F, 32'h000003CC, 32'h00000000};
    a_v = {4{32'h800000F3}};
    b_v = {4{32'h00000004}};
    held = '0;
    exp_q.delete();
    idx = 0; delivered = 0; stall_seen = 0; have_held = 1'b0;
    idle_cycle();
    for (int c = 0; c < 60 && delivered < 9; c++) begin
      if32.out_ready = !(c >= 4 && c <= 6);
      #1;
      if (if32.out_valid && !if32.out_ready) begin
        stall_seen++;
        checks++;
        if (if32.in_ready !== 1'b0) begin
          failures++; $display("FAIL stall_in_ready cycle=%0d got %b want 0", c, if32.in_ready);
        end
        if (have_held) begin
          checks++;
          if (if32.out !== held) begin
            failures++; $display("FAIL stall_hold cycle=%0d got %h want %h", c, if32.out, held);
          end
        end else begin
          held = if32.out;
          have_held = 1'b1;
        end
      end else begin
        checks++;
        if (if32.in_ready !== 1'b1) begin
          failures++; $display("FAIL run_in_ready cycle=%0d got %b want 1", c, if32.in_ready);
        end
        if (if32.out_valid) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++; $display("FAIL b2b_extra cycle=%0d got %h want none", c, if32.out);
          end else begin
            exp_v = exp_q.pop_front();
            if (if32.out !== exp_v) begin
              failures++; $display("FAIL b2b_order cycle=%0d got %h want %h", c, if32.out, exp_v);
            end
          end
          delivered++;
        end
      end
      if (if32.in_ready && idx < 9) begin
        set_in(0, 1'b1, a_v, b_v, ops[idx]);
        exp_q.push_back({4{expv[idx]}});
        idx++;
      end else if (idx < 9) begin
        set_in(0, 1'b1, ~a_v, a_v, OP_PASS);  // must be ignored while stalled
      end else begin
        set_in(0, 1'b0, '0, '0, 4'h0);
      end
      @(posedge clk); #1;
    end
    if32.out_ready = 1'b1;
    set_in(0, 1'b0, '0, '0, 4'h0);
    checks++;
    if (delivered != 9 || exp_q.size() != 0) begin
      failures++; $display("FAIL b2b_count got delivered=%0d left=%0d want 9 0", delivered, exp_q.size());
    end
    checks++;
    if (stall_seen != 3) begin
      failures++; $display("FAIL stall_cycles got %0d want 3", stall_seen);
    end
  endtask

  task automatic test_reset_midflight();
    int stale;
    idle_cycle();
    set_in(0, 1'b1, {4{32'd1}}, {4{32'd2}}, OP_ADD);
    @(posedge clk); #1;
    set_in(0, 1'b1, {4{32'd7}}, {4{32'd2}}, OP_SUB);
    @(posedge clk); #1;
    set_in(0, 1'b0, '0, '0, 4'h0);
    checks++;
    if (if32.out_valid !== 1'b1 || if32.out !== {4{32'd3}}) begin
      failures++; $display("FAIL inflight_before_rst got vld=%b out=%h want 1 %h", if32.out_valid, if32.out, {4{32'd3}});
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (if32.out_valid !== 1'b0 || if32.out !== 128'd0 || if32.zero_signal !== 1'b1 ||
        if32.illegal_op !== 1'b0 || if32.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL async_rst got vld=%b out=%h zero=%b ill=%b rdy=%b want 0 0 1 0 1",
               if32.out_valid, if32.out, if32.zero_signal, if32.illegal_op, if32.in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    stale = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (if32.out_valid) stale++;
    end
    checks++;
    if (stale != 0) begin
      failures++; $display("FAIL stale_after_rst got %0d valid cycles want 0", stale);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_latency();
    test_lane8();
    test_cmp_illegal();
    test_sat();
    test_back_to_back();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
